// File: rtl/intp_pkg.sv
// Shared constants for the interrupt source conditioner: register map and default sizing.
// Defining INTP_SRC_COND_OVERRUN_EN maps the OVERRUN register at ADDR_OVERRUN.
package intp_pkg;

    localparam int DEF_NUM_OF_PERIPHERALS = 16;
    localparam int DEF_ID_WIDTH           = 4;

    localparam int ADDR_ENABLE   = 0;
    localparam int ADDR_EDGE_SEL = 1;
    localparam int ADDR_POLARITY = 2;
    localparam int ADDR_PENDING  = 3;
    localparam int ADDR_STATUS   = 4;
    localparam int ADDR_OVERRUN  = 5;

    // Whether a register address decodes to an implemented register.
    function automatic logic is_mapped(input int addr);
`ifdef INTP_SRC_COND_OVERRUN_EN
        return (addr >= ADDR_ENABLE) && (addr <= ADDR_OVERRUN);
`else
        return (addr >= ADDR_ENABLE) && (addr <= ADDR_STATUS);
`endif
    endfunction

endpackage

// File: rtl/intp_sync_edge.sv
// Per-source front end: synchronises a raw interrupt line, applies polarity,
// and flags a rising edge of the conditioned level.
module intp_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic polarity,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1] ^ polarity;
    assign rise = s & ~prev_q;

endmodule

// File: rtl/intp_src_cond.sv
// Interrupt source conditioner: APB-configured enable/edge/polarity, pending latch,
// registered intp_active_o. Optional OVERRUN register via INTP_SRC_COND_OVERRUN_EN.
module intp_src_cond
    import intp_pkg::*;
#(
    parameter int NUM_OF_PERIPHERALS = DEF_NUM_OF_PERIPHERALS,
    parameter int ID_WIDTH           = DEF_ID_WIDTH,
    parameter int SYNC_STAGES        = 2,
    parameter int ADDR_WIDTH         = 3
) (
    input  logic                          pclk_i,
    input  logic                          prst_n_i,
    input  logic [NUM_OF_PERIPHERALS-1:0] irq_raw_i,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pwrite_i,
    input  logic [ADDR_WIDTH-1:0]         paddr_i,
    input  logic [NUM_OF_PERIPHERALS-1:0] pwdata_i,
    output logic [NUM_OF_PERIPHERALS-1:0] prdata_o,
    output logic                          pready_o,
    output logic                          perror_o,
    input  logic                          intp_serviced_i,
    input  logic [ID_WIDTH-1:0]           intp_serviced_id_i,
    output logic [NUM_OF_PERIPHERALS-1:0] intp_active_o
);

    localparam int N = NUM_OF_PERIPHERALS;

    logic [N-1:0] enable_q, edge_sel_q, polarity_q, pending_q, active_q;
    logic [N-1:0] s, rise, svc_hit, clr;
    logic         access, wr_ok;
    int           addr;

    for (genvar i = 0; i < N; i++) begin : g_src
        intp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
            .clk      (pclk_i),
            .rst_n    (prst_n_i),
            .raw      (irq_raw_i[i]),
            .polarity (polarity_q[i]),
            .s        (s[i]),
            .rise     (rise[i])
        );
    end

    assign addr     = int'(paddr_i);
    assign access   = psel_i & penable_i;
    assign pready_o = access;
    assign perror_o = access & (~is_mapped(addr) | (pwrite_i & (addr == ADDR_STATUS)));
    assign wr_ok    = access & pwrite_i & ~perror_o;

`ifdef INTP_SRC_COND_OVERRUN_EN
    logic [N-1:0] overrun_q;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        prdata_o = '0;
        if (access && !pwrite_i && !perror_o) begin
            case (addr)
                ADDR_ENABLE:   prdata_o = enable_q;
                ADDR_EDGE_SEL: prdata_o = edge_sel_q;
                ADDR_POLARITY: prdata_o = polarity_q;
                ADDR_PENDING:  prdata_o = pending_q;
                ADDR_STATUS:   prdata_o = s;
`ifdef INTP_SRC_COND_OVERRUN_EN
                ADDR_OVERRUN:  prdata_o = overrun_q;
`endif
                default:       prdata_o = '0;
            endcase
        end
    end

    // Out-of-range IDs never match any source index.
    always_comb begin
        svc_hit = '0;
        for (int i = 0; i < N; i++) begin
            svc_hit[i] = intp_serviced_i && (int'(intp_serviced_id_i) == i);
        end
        clr = svc_hit | ((wr_ok && addr == ADDR_PENDING) ? pwdata_i : '0);
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            enable_q   <= '0;
            edge_sel_q <= '0;
            polarity_q <= '0;
            pending_q  <= '0;
            active_q   <= '0;
        end else begin
            if (wr_ok && addr == ADDR_ENABLE)   enable_q   <= pwdata_i;
            if (wr_ok && addr == ADDR_EDGE_SEL) edge_sel_q <= pwdata_i;
            if (wr_ok && addr == ADDR_POLARITY) polarity_q <= pwdata_i;
            // Edge sources: a new edge beats a same-cycle clear. Level sources follow s.
            pending_q <= (edge_sel_q & ((pending_q & ~clr) | rise)) | (~edge_sel_q & s);
            active_q  <= pending_q & enable_q;
        end
    end

`ifdef INTP_SRC_COND_OVERRUN_EN
    logic [N-1:0] ovr_clr;
    assign ovr_clr = (wr_ok && addr == ADDR_OVERRUN) ? pwdata_i : '0;

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= (edge_sel_q & rise & pending_q & ~clr) | (overrun_q & ~ovr_clr);
        end
    end
`endif

    assign intp_active_o = active_q;

endmodule

// File: tb/tb_intp_src_cond.sv
// Self-checking bench for intp_src_cond: directed scenarios plus random traffic
// compared every cycle against a cycle-level behavioural model.
module tb_intp_src_cond;

    localparam int N    = 16;
    localparam int IDW  = 4;
    localparam int SYNC = 2;
    localparam int AW   = 3;

    logic           pclk = 1'b0;
    logic           prst_n;
    logic [N-1:0]   irq_raw;
    logic           psel, penable, pwrite;
    logic [AW-1:0]  paddr;
    logic [N-1:0]   pwdata, prdata;
    logic           pready, perror;
    logic           svc;
    logic [IDW-1:0] svc_id;
    logic [N-1:0]   intp_active;

    intp_src_cond #(
        .NUM_OF_PERIPHERALS(N), .ID_WIDTH(IDW), .SYNC_STAGES(SYNC), .ADDR_WIDTH(AW)
    ) dut (
        .pclk_i             (pclk),
        .prst_n_i           (prst_n),
        .irq_raw_i          (irq_raw),
        .psel_i             (psel),
        .penable_i          (penable),
        .pwrite_i           (pwrite),
        .paddr_i            (paddr),
        .pwdata_i           (pwdata),
        .prdata_o           (prdata),
        .pready_o           (pready),
        .perror_o           (perror),
        .intp_serviced_i    (svc),
        .intp_serviced_id_i (svc_id),
        .intp_active_o      (intp_active)
    );

    always #5 pclk = ~pclk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state: register file, pending/overrun sets and the last
    // SYNC sampled raw vectors (raw seen by the source logic SYNC edges later).
    logic [N-1:0] m_en, m_edge, m_pol, m_pend, m_ovr, m_active, m_prev;
    logic [N-1:0] raw_hist [SYNC];
    logic [N-1:0] last_rdata;
    logic         last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_edge = '0; m_pol = '0; m_pend = '0;
        m_ovr = '0; m_active = '0; m_prev = '0;
        for (int k = 0; k < SYNC; k++) raw_hist[k] = '0;
    endtask

    function automatic logic model_err();
        int a;
        logic known;
        a = int'(paddr);
`ifdef INTP_SRC_COND_OVERRUN_EN
        known = (a <= 5);
`else
        known = (a <= 4);
`endif
        return psel && penable && (!known || (pwrite && a == 4));
    endfunction

    function automatic logic [N-1:0] model_read();
        if (model_err()) return '0;
        case (int'(paddr))
            0: return m_en;
            1: return m_edge;
            2: return m_pol;
            3: return m_pend;
            4: return raw_hist[SYNC-1] ^ m_pol;
            5: return m_ovr;
            default: return '0;
        endcase
    endfunction

    // One clock edge: derive the model's next state from the pre-edge inputs,
    // then compare intp_active after the edge.
    task automatic tick();
        logic [N-1:0] s_now, rise, clr, n_pend, n_ovr, n_active;
        logic         wr;
        int           a;
        s_now = raw_hist[SYNC-1] ^ m_pol;
        rise  = s_now & ~m_prev;
        a     = int'(paddr);
        wr    = psel && penable && pwrite && !model_err();
        clr   = '0;
        if (svc && int'(svc_id) < N) clr[svc_id] = 1'b1;
        if (wr && a == 3) clr = clr | pwdata;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (rise[i])      n_pend[i] = 1'b1;
                else if (clr[i])  n_pend[i] = 1'b0;
                else              n_pend[i] = m_pend[i];
                if (rise[i] && m_pend[i] && !clr[i]) n_ovr[i] = 1'b1;
                else if (wr && a == 5 && pwdata[i])  n_ovr[i] = 1'b0;
                else                                 n_ovr[i] = m_ovr[i];
            end else begin
                n_pend[i] = s_now[i];
                n_ovr[i]  = (wr && a == 5 && pwdata[i]) ? 1'b0 : m_ovr[i];
            end
        end
        n_active = m_pend & m_en;
        @(posedge pclk);
        #1;
        for (int k = SYNC - 1; k > 0; k--) raw_hist[k] = raw_hist[k-1];
        raw_hist[0] = irq_raw;
        m_prev   = s_now;
        m_pend   = n_pend;
        m_ovr    = n_ovr;
        m_active = n_active;
        if (wr && a == 0) m_en   = pwdata;
        if (wr && a == 1) m_edge = pwdata;
        if (wr && a == 2) m_pol  = pwdata;
        check("active", 32'(intp_active), 32'(m_active));
        @(negedge pclk);
    endtask

    task automatic apb_write(input int a, input logic [N-1:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(a); pwdata = d;
        tick();
        penable = 1'b1;
        #1;
        last_err = perror;
        check("wr_pready", 32'(pready), 32'd1);
        check("wr_perror", 32'(perror), 32'(model_err()));
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input int a);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(a);
        tick();
        penable = 1'b1;
        #1;
        last_err   = perror;
        last_rdata = prdata;
        check("rd_pready", 32'(pready), 32'd1);
        check("rd_perror", 32'(perror), 32'(model_err()));
        check("rd_data", 32'(prdata), 32'(model_read()));
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        prst_n = 1'b0; irq_raw = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; svc = 1'b0; svc_id = '0;
        model_reset();
        #1;
        check("rst_active", 32'(intp_active), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_perror", 32'(perror), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;

        // Every register reads back zero after reset.
        for (int a = 0; a < 8; a++) begin
            apb_read(a);
            check("rst_reg", 32'(last_rdata), 32'd0);
        end

        // Edge source 0: visible SYNC+2 edges after assertion, held until serviced.
        apb_write(0, 16'hFFFF);
        apb_write(1, 16'h0001);
        irq_raw[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("edge0_lat", 32'(intp_active[0]), (c >= 4) ? 32'd1 : 32'd0);
        end
        irq_raw[0] = 1'b0;
        repeat (4) tick();
        check("edge0_held", 32'(intp_active[0]), 32'd1);
        svc = 1'b1; svc_id = 4'd0;
        tick();
        svc = 1'b0;
        tick();
        check("edge0_svc", 32'(intp_active[0]), 32'd0);

        // Level source 3 tracks the line; a service pulse mid-pulse changes nothing.
        irq_raw[3] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            svc = (c == 6); svc_id = 4'd3;
            tick();
            if (c >= 4) check("lvl3_high", 32'(intp_active[3]), 32'd1);
        end
        svc = 1'b0;
        irq_raw[3] = 1'b0;
        repeat (4) tick();
        check("lvl3_low", 32'(intp_active[3]), 32'd0);

        // Active-low edge source 5: flip-generated edge is cleared, then a real
        // 1->0 edge coincides with a W1C and must survive.
        apb_write(1, 16'h0021);
        apb_write(2, 16'h0020);
        apb_write(3, 16'h0020);
        irq_raw[5] = 1'b1;
        repeat (3) tick();
        irq_raw[5] = 1'b0;
        tick();
        apb_write(3, 16'h0020);
        apb_read(3);
        check("pend5_kept", 32'(last_rdata[5]), 32'd1);

        // Error accesses change nothing.
        apb_write(4, 16'hFFFF);
        check("err_wr4", 32'(last_err), 32'd1);
        apb_write(6, 16'h1234);
        check("err_wr6", 32'(last_err), 32'd1);
        apb_read(0);
        check("en_intact", 32'(last_rdata), 32'h0000FFFF);
        apb_read(7);
        check("err_rd7", 32'(last_err), 32'd1);
        check("rd7_data", 32'(last_rdata), 32'd0);

        // Two edges on source 2 without service.
        apb_write(1, 16'h0025);
        for (int p = 0; p < 2; p++) begin
            irq_raw[2] = 1'b1;
            repeat (3) tick();
            irq_raw[2] = 1'b0;
            repeat (3) tick();
        end
        apb_read(5);
`ifdef INTP_SRC_COND_OVERRUN_EN
        check("ovr_set", 32'(last_rdata), 32'h00000004);
        apb_write(5, 16'h0004);
        apb_read(5);
        check("ovr_clr", 32'(last_rdata), 32'd0);
`else
        check("ovr_unmapped", 32'(last_err), 32'd1);
`endif

        // Random traffic against the model.
        for (int it = 0; it < 300; it++) begin
            irq_raw = N'($urandom);
            svc     = ($urandom_range(0, 3) == 0);
            svc_id  = IDW'($urandom_range(0, 15));
            tick();
            if ($urandom_range(0, 7) == 0) begin
                svc = 1'b0;
                if ($urandom_range(0, 1) == 0) apb_write(int'($urandom_range(0, 7)), N'($urandom));
                else                           apb_read(int'($urandom_range(0, 7)));
            end
        end
        svc = 1'b0;

        // Reset in mid-operation drops the outputs at once.
        irq_raw = 16'hFFFF;
        apb_write(0, 16'hFFFF);
        apb_write(1, 16'h0000);
        apb_write(2, 16'h0000);
        repeat (5) tick();
        check("all_active", 32'(intp_active), 32'h0000FFFF);
        #2;
        prst_n = 1'b0;
        #1;
        check("async_rst", 32'(intp_active), 32'd0);
        model_reset();
        @(negedge pclk);
        prst_n = 1'b1;
        repeat (6) tick();
        apb_read(3);
        check("post_rst_pend", 32'(last_rdata), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intp_src_cond.md
Name: intp_src_cond

Overview:
- Per-peripheral interrupt source conditioner that sits directly upstream of the interrupt controller.
- Synchronises raw peripheral interrupt lines into pclk_i, applies polarity, level/edge mode and enable, and latches edge events as pending.
- Drives the controller's intp_active vector.
- Clears pending bits when the controller/processor reports an interrupt serviced, and is configured over an APB slave port.

Parameters:
- NUM_OF_PERIPHERALS, 16, number of interrupt sources; width of every per-source vector.
- ID_WIDTH, 4, width of serviced-peripheral ID; equals $clog2(NUM_OF_PERIPHERALS).
- SYNC_STAGES, 2, flops in each input synchroniser (min 2).
- ADDR_WIDTH, 3, APB register address width.

Ports:
- pclk_i  in  1  clock
- prst_n_i  in  1  asynchronous active-low reset
- irq_raw_i  in  NUM_OF_PERIPHERALS  raw asynchronous peripheral interrupt lines
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- pwrite_i  in  1  APB 1=write 0=read
- paddr_i  in  ADDR_WIDTH  APB register address
- pwdata_i  in  NUM_OF_PERIPHERALS  APB write data
- prdata_o  out  NUM_OF_PERIPHERALS  APB read data
- pready_o  out  1  APB ready
- perror_o  out  1  APB slave error
- intp_serviced_i  in  1  one-cycle pulse: interrupt intp_serviced_id_i completed
- intp_serviced_id_i  in  ID_WIDTH  ID of the serviced peripheral
- intp_active_o  out  NUM_OF_PERIPHERALS  conditioned requests to the interrupt controller

Behaviour:
- Clock and reset: single clock pclk_i. Reset prst_n_i is asynchronous, active-low; all flops clear immediately on assertion, release synchronously to pclk_i.
- Reset values: intp_active_o=0, prdata_o=0, pready_o=0, perror_o=0. Registers: ENABLE=0, EDGE_SEL=0, POLARITY=0, PENDING=0, synchronisers=0.
- Register map (address: name, access):
  - 0: ENABLE, RW.
  - 1: EDGE_SEL, RW; 1=rising-edge mode, 0=level mode.
  - 2: POLARITY, RW; 1=active-low source.
  - 3: PENDING, read / write-1-to-clear.
  - 4: STATUS, RO; synchronised raw lines after polarity.
  - 5-7: unmapped.
- APB timing: zero wait state. Access = psel_i & penable_i; pready_o = access, combinational.
- Writes take effect at the access-phase clock edge.
- prdata_o is a combinational read mux, valid during a read access and 0 otherwise.
- perror_o = access & (address unmapped, or write to STATUS). An errored access changes no state and reads 0.
- Per source i:
  - s[i] = sync(irq_raw_i[i]) XOR POLARITY[i]; prev[i] = s[i] delayed one cycle.
  - Level mode: PENDING[i] <= s[i] every cycle. Service and W1C have no lasting effect.
  - Edge mode: set when s[i] & ~prev[i]. Clear on intp_serviced_i with intp_serviced_id_i==i, or on a W1C write of bit i.
- Set priority: an edge and a clear in the same cycle leave PENDING set, so no event is lost.
- intp_active_o = PENDING & ENABLE, registered. Latency from a raw assertion (held ≥ SYNC_STAGES+1 cycles) to intp_active_o high is SYNC_STAGES+2 pclk_i edges.
- Disabling a source masks its output but does not clear PENDING; re-enabling re-presents a held pending edge.
- Changing EDGE_SEL or POLARITY at runtime:
  - prev is not reset.
  - A polarity flip may itself generate one edge; software clears PENDING afterwards.
- intp_serviced_id_i ≥ NUM_OF_PERIPHERALS is ignored.
- Reset asserted mid-operation: pending events are discarded, outputs drop asynchronously.

Optional Feature:
- Macro: INTP_SRC_COND_OVERRUN_EN.
- Defined:
  - Adds register 5 OVERRUN, read / W1C.
  - OVERRUN[i] is set when an edge-mode rising edge arrives while PENDING[i] is already 1 and not being cleared that cycle.
  - Set wins over a simultaneous W1C. Reset value 0.
- Undefined: address 5 is unmapped (perror_o), and no overrun logic is present.

Decomposition:
- Package intp_pkg holds:
  - register address localparams (ADDR_ENABLE=0 … ADDR_STATUS=4, ADDR_OVERRUN=5);
  - default NUM_OF_PERIPHERALS and ID_WIDTH.
- Sub-module intp_sync_edge, instantiated per source: SYNC_STAGES synchroniser, polarity XOR, prev flop, outputs s and rise.
- The top holds the registers, pending logic and APB decode.

Test Plan:
- Reset, then read all registers → every register 0, intp_active_o=0, perror_o=0, pready_o=1 during each access.
- ENABLE=0xFFFF, EDGE_SEL=0x0001; pulse irq_raw_i[0] for 5 cycles → intp_active_o[0] rises 4 edges after assertion and stays high after the pulse ends. intp_serviced_i with ID 0 → bit 0 low next edge.
- Level source 3 (EDGE_SEL[3]=0): hold irq_raw_i[3] high 10 cycles, then low → intp_active_o[3] tracks with 4-cycle lag. intp_serviced_i with ID 3 mid-pulse has no effect.
- POLARITY[5]=1, edge mode: drive irq_raw_i[5] 1→0 → PENDING[5]=1. Same-cycle W1C of bit 5 coinciding with a new synchronised edge → PENDING[5] stays 1.
- Write to address 4 and to address 6 → perror_o=1 both times, no register change. Read address 7 → prdata_o=0, perror_o=1.
- With INTP_SRC_COND_OVERRUN_EN defined: two edges on source 2 with no service → OVERRUN=0x0004; W1C 0x0004 → 0. Without the macro, an access to address 5 gives perror_o=1.
